// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the 16-bit CPU controller: widths, opcode/ext fields,
// condition codes, FSM states and the instruction-class decoder.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef REGWIDTH
`define REGWIDTH 4
`endif

package cpu_controller_pkg;

  localparam int DW = `DATAWIDTH;
  localparam int RW = `REGWIDTH;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STOR,
    CLS_JCOND,
    CLS_JAL,
    CLS_BCOND
  } iclass_t;

  localparam logic [3:0] OP_RTYPE   = 4'h0;
  localparam logic [3:0] OP_SPECIAL = 4'h4;
  localparam logic [3:0] OP_BCOND   = 4'hC;
  localparam logic [3:0] OP_NOP_LO  = 4'hD;

  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_UC = 4'hE;

  localparam logic [3:0]    ALU_NONE = 4'h0;
  localparam logic [RW-1:0] LINK_REG = 4'hF;

  function automatic iclass_t decode_class(input logic [DW-1:0] ir);
    iclass_t cls;
    cls = CLS_NOP;
    if (ir[15:12] == OP_RTYPE) begin
      cls = CLS_ALU_R;
    end else if (ir[15:12] == OP_SPECIAL) begin
      case (ir[7:4])
        EXT_LOAD:  cls = CLS_LOAD;
        EXT_STOR:  cls = CLS_STOR;
        EXT_JAL:   cls = CLS_JAL;
        EXT_JCOND: cls = CLS_JCOND;
        default:   cls = CLS_NOP;
      endcase
    end else if (ir[15:12] == OP_BCOND) begin
      cls = CLS_BCOND;
    end else if (ir[15:12] >= OP_NOP_LO) begin
      cls = CLS_NOP;
    end else begin
      cls = CLS_ALU_I;
    end
    return cls;
  endfunction

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the PSR
// zero/less-than flags onto a taken decision.
module cpu_controller_cond_eval
  import cpu_controller_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flag_z;
      COND_NE: taken = ~flag_z;
      COND_LT: taken = flag_n;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute/writeback controller. Owns PC and IR and
// drives every datapath control from flops so nothing downstream sees a glitch.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [DW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          imem_ack,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ack,
  output logic [RW-1:0] rSrc,
  output logic [RW-1:0] rDst,
  output logic          write,
  output logic [DW-1:0] pc,
  input  logic [DW-1:0] dSrc,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] imm,
  output logic          imm_sel,
  output logic          wb_sel,
  output logic          flags_we,
  input  logic          flag_z,
  input  logic          flag_n
);

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          imem_req_q, imem_req_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic          write_q, write_d;
  logic          flags_we_q, flags_we_d;
  logic          imm_sel_q, imm_sel_d;
  logic          wb_sel_q, wb_sel_d;
  logic [RW-1:0] rsrc_q, rsrc_d;
  logic [RW-1:0] rdst_q, rdst_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [DW-1:0] imm_q, imm_d;

  iclass_t cls_cur, cls_nxt;
  logic    cond_taken;

  assign cls_cur = decode_class(ir_q);
  assign cls_nxt = decode_class(ir_d);

  cpu_controller_cond_eval u_cond_eval (
    .cond   (ir_q[11:8]),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .taken  (cond_taken)
  );

  // Acks only count while our own request flop is high, so stray or late acks are harmless.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        pc_d    = pc_q + 16'd1;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (cls_cur)
          CLS_ALU_R, CLS_ALU_I, CLS_JAL: state_d = ST_WRITEBACK;
          CLS_LOAD, CLS_STOR:            state_d = ST_MEM;
          CLS_BCOND: begin
            if (cond_taken) pc_d = pc_q + sext8(ir_q[7:0]);
            state_d = ST_FETCH;
          end
          CLS_JCOND: begin
            if (cond_taken) pc_d = dSrc;
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          state_d = (cls_cur == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        if (cls_cur == CLS_JAL) pc_d = dSrc;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are computed for the state being entered and then registered.
  always_comb begin
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) && (cls_nxt == CLS_STOR);
    flags_we_d = (state_d == ST_EXECUTE) &&
                 ((cls_nxt == CLS_ALU_R) || (cls_nxt == CLS_ALU_I));
    write_d    = (state_d == ST_WRITEBACK);
    wb_sel_d   = (state_d == ST_WRITEBACK) && (cls_nxt == CLS_LOAD);
    rsrc_d     = ir_d[3:0];
    rdst_d     = ((state_d == ST_WRITEBACK) && (cls_nxt == CLS_JAL)) ? LINK_REG : ir_d[11:8];
    imm_sel_d  = (cls_nxt == CLS_ALU_I);
    imm_d      = (cls_nxt == CLS_ALU_I) ? sext8(ir_d[7:0]) : '0;
    alu_op_d   = ALU_NONE;
    if (cls_nxt == CLS_ALU_R) alu_op_d = ir_d[7:4];
    else if (cls_nxt == CLS_ALU_I) alu_op_d = ir_d[15:12];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      write_q    <= 1'b0;
      flags_we_q <= 1'b0;
      imm_sel_q  <= 1'b0;
      wb_sel_q   <= 1'b0;
      rsrc_q     <= '0;
      rdst_q     <= '0;
      alu_op_q   <= '0;
      imm_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      write_q    <= write_d;
      flags_we_q <= flags_we_d;
      imm_sel_q  <= imm_sel_d;
      wb_sel_q   <= wb_sel_d;
      rsrc_q     <= rsrc_d;
      rdst_q     <= rdst_d;
      alu_op_q   <= alu_op_d;
      imm_q      <= imm_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign write     = write_q;
  assign flags_we  = flags_we_q;
  assign imm_sel   = imm_sel_q;
  assign wb_sel    = wb_sel_q;
  assign rSrc      = rsrc_q;
  assign rDst      = rdst_q;
  assign alu_op    = alu_op_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller: each task walks one instruction
// class cycle by cycle against hand-computed expectations.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [3:0]  rSrc;
  logic [3:0]  rDst;
  logic        write;
  logic [15:0] pc;
  logic [15:0] dSrc;
  logic [3:0]  alu_op;
  logic [15:0] imm;
  logic        imm_sel;
  logic        wb_sel;
  logic        flags_we;
  logic        flag_z;
  logic        flag_n;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] cur_pc;

  cpu_controller #(.RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rSrc       (rSrc),
    .rDst       (rDst),
    .write      (write),
    .pc         (pc),
    .dSrc       (dSrc),
    .alu_op     (alu_op),
    .imm        (imm),
    .imm_sel    (imm_sel),
    .wb_sel     (wb_sel),
    .flags_we   (flags_we),
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request at cur_pc and acks it; returns in DECODE.
  task automatic fetch_instr(input logic [15:0] instr);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fetch_timeout imem_req=%b exp=1 within 8 cycles", imem_req);
    end
    vectors++;
    if (imem_addr !== cur_pc) begin
      miscompares++;
      $display("[TB] FAIL fetch_addr got=%h exp=%h", imem_addr, cur_pc);
    end
    imem_rdata = instr;
    imem_ack   = 1'b1;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic goto_pc(input logic [15:0] target);
    dSrc = target;
    fetch_instr(16'h4EC0);
    tick();
    tick();
    cur_pc = target;
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, target}) begin
      miscompares++;
      $display("[TB] FAIL jcond_uc req/addr got=%b/%h exp=1/%h", imem_req, imem_addr, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({imem_req, dmem_req, dmem_we, write, flags_we, imm_sel, wb_sel} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0000000",
               {imem_req, dmem_req, dmem_we, write, flags_we, imm_sel, wb_sel});
    end
    vectors++;
    if ({rSrc, rDst, alu_op, imm, pc} !== 44'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_fields got=%h exp=0", {rSrc, rDst, alu_op, imm, pc});
    end
    reset = 1'b0;
    tick();
    cur_pc = 16'h0000;
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL reset_first_fetch got=%b/%h exp=1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_rtype();
    fetch_instr(16'h0354);
    vectors++;
    if ({rDst, rSrc, alu_op, write, flags_we} !== {4'h3, 4'h4, 4'h5, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL rtype_decode got=%h/%h/%h/%b/%b exp=3/4/5/0/0", rDst, rSrc, alu_op, write, flags_we);
    end
    tick();
    vectors++;
    if ({flags_we, write, imm_sel, pc} !== {3'b100, 16'h0001}) begin
      miscompares++;
      $display("[TB] FAIL rtype_exec got=%b%b%b/%h exp=100/0001", flags_we, write, imm_sel, pc);
    end
    tick();
    vectors++;
    if ({write, flags_we, wb_sel, rDst} !== {3'b100, 4'h3}) begin
      miscompares++;
      $display("[TB] FAIL rtype_wb got=%b%b%b/%h exp=100/3", write, flags_we, wb_sel, rDst);
    end
    tick();
    cur_pc = 16'h0001;
    vectors++;
    if ({write, imem_req, imem_addr} !== {2'b01, cur_pc}) begin
      miscompares++;
      $display("[TB] FAIL rtype_next got=%b%b/%h exp=01/%h", write, imem_req, imem_addr, cur_pc);
    end
  endtask

  task automatic test_imm_alu();
    fetch_instr(16'h52F0);
    vectors++;
    if ({alu_op, imm, imm_sel, rDst} !== {4'h5, 16'hFFF0, 1'b1, 4'h2}) begin
      miscompares++;
      $display("[TB] FAIL imm_decode got=%h/%h/%b/%h exp=5/fff0/1/2", alu_op, imm, imm_sel, rDst);
    end
    tick();
    vectors++;
    if (flags_we !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL imm_flags_we got=%b exp=1", flags_we);
    end
    tick();
    vectors++;
    if ({write, wb_sel} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL imm_wb got=%b%b exp=10", write, wb_sel);
    end
    tick();
    cur_pc = 16'h0002;
  endtask

  task automatic test_load();
    fetch_instr(16'h4207);
    vectors++;
    if ({rDst, rSrc} !== 8'h27) begin
      miscompares++;
      $display("[TB] FAIL load_regs got=%h%h exp=27", rDst, rSrc);
    end
    tick();
    vectors++;
    if ({flags_we, dmem_req} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL load_exec got=%b%b exp=00", flags_we, dmem_req);
    end
    tick();
    for (int k = 1; k <= 4; k++) begin
      vectors++;
      if ({dmem_req, dmem_we, write} !== 3'b100) begin
        miscompares++;
        $display("[TB] FAIL load_mem_cycle%0d got=%b%b%b exp=100", k, dmem_req, dmem_we, write);
      end
      if (k == 4) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    vectors++;
    if ({write, wb_sel, dmem_req, rDst} !== {3'b110, 4'h2}) begin
      miscompares++;
      $display("[TB] FAIL load_wb got=%b%b%b/%h exp=110/2", write, wb_sel, dmem_req, rDst);
    end
    tick();
    cur_pc = 16'h0003;
    vectors++;
    if ({write, wb_sel, imem_req, imem_addr} !== {3'b001, cur_pc}) begin
      miscompares++;
      $display("[TB] FAIL load_next got=%b%b%b/%h exp=001/%h", write, wb_sel, imem_req, imem_addr, cur_pc);
    end
  endtask

  task automatic test_store();
    fetch_instr(16'h4146);
    tick();
    tick();
    vectors++;
    if ({dmem_req, dmem_we} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL stor_mem got=%b%b exp=11", dmem_req, dmem_we);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    cur_pc = 16'h0004;
    vectors++;
    if ({write, dmem_req, imem_req, imem_addr} !== {3'b001, cur_pc}) begin
      miscompares++;
      $display("[TB] FAIL stor_next got=%b%b%b/%h exp=001/%h", write, dmem_req, imem_req, imem_addr, cur_pc);
    end
  endtask

  task automatic test_jcond_not_taken();
    flag_z = 1'b0;
    dSrc   = 16'h5555;
    fetch_instr(16'h40C3);
    tick();
    tick();
    cur_pc = 16'h0005;
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, cur_pc}) begin
      miscompares++;
      $display("[TB] FAIL jcond_nt got=%b/%h exp=1/%h", imem_req, imem_addr, cur_pc);
    end
  endtask

  task automatic test_branches();
    logic [3:0] conds [9] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hC, 4'hC, 4'hE, 4'h2, 4'hF};
    logic       zs    [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       ns    [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       tks   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      goto_pc(16'h0010);
      flag_z = zs[i];
      flag_n = ns[i];
      fetch_instr({4'hC, conds[i], 8'hFE});
      tick();
      tick();
      cur_pc = tks[i] ? 16'h000F : 16'h0011;
      vectors++;
      if ({imem_req, imem_addr} !== {1'b1, cur_pc}) begin
        miscompares++;
        $display("[TB] FAIL bcond_%0d cond=%h got=%b/%h exp=1/%h", i, conds[i], imem_req, imem_addr, cur_pc);
      end
    end
    flag_z = 1'b0;
    flag_n = 1'b0;
  endtask

  task automatic test_jal();
    goto_pc(16'h0040);
    dSrc = 16'h1234;
    fetch_instr(16'h4085);
    vectors++;
    if (rDst !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL jal_decode_rdst got=%h exp=0", rDst);
    end
    tick();
    vectors++;
    if ({write, flags_we} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL jal_exec got=%b%b exp=00", write, flags_we);
    end
    tick();
    vectors++;
    if ({write, wb_sel, rDst, pc} !== {2'b10, 4'hF, 16'h0041}) begin
      miscompares++;
      $display("[TB] FAIL jal_wb got=%b%b/%h/%h exp=10/f/0041", write, wb_sel, rDst, pc);
    end
    tick();
    cur_pc = 16'h1234;
    vectors++;
    if ({write, imem_req, imem_addr} !== {2'b01, cur_pc}) begin
      miscompares++;
      $display("[TB] FAIL jal_next got=%b%b/%h exp=01/1234", write, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_stray_ack();
    goto_pc(16'hFFFF);
    fetch_instr(16'hD000);
    imem_rdata = 16'h0354;
    imem_ack   = 1'b1;
    tick();
    vectors++;
    if ({write, flags_we, imem_req, pc} !== {3'b000, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL nop_exec got=%b%b%b/%h exp=000/0000", write, flags_we, imem_req, pc);
    end
    tick();
    imem_ack = 1'b0;
    cur_pc = 16'h0000;
    vectors++;
    if ({write, imem_req, imem_addr} !== {2'b01, cur_pc}) begin
      miscompares++;
      $display("[TB] FAIL nop_wrap got=%b%b/%h exp=01/0000", write, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_mem();
    fetch_instr(16'h4207);
    tick();
    tick();
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmem_pre got=%b exp=1", dmem_req);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({dmem_req, write, pc} !== {2'b00, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL rstmem_async got=%b%b/%h exp=00/0000", dmem_req, write, pc);
    end
    tick();
    reset    = 1'b0;
    dmem_ack = 1'b1;
    tick();
    vectors++;
    if ({imem_req, dmem_req, write, imem_addr} !== {3'b100, 16'h0000}) begin
      miscompares++;
      $display("[TB] FAIL rstmem_fetch got=%b%b%b/%h exp=100/0000", imem_req, dmem_req, write, imem_addr);
    end
    tick();
    vectors++;
    if ({imem_req, dmem_req, write, wb_sel} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL rstmem_late_ack got=%b%b%b%b exp=1000", imem_req, dmem_req, write, wb_sel);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    imem_rdata = 16'h0000;
    imem_ack   = 1'b0;
    dmem_ack   = 1'b0;
    dSrc       = 16'h0000;
    flag_z     = 1'b0;
    flag_n     = 1'b0;
    cur_pc     = 16'h0000;
    test_reset();
    test_rtype();
    test_imm_alu();
    test_load();
    test_store();
    test_jcond_not_taken();
    test_branches();
    test_jal();
    test_wrap_stray_ack();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
